// File: rtl/free_list_if.sv
// free_list_if: dispatch/retire/rollback bundle between the pipeline and the physical-register free list
//   master: pipeline side (drives enables, destinations, retired tags, rollback pointer)
//   slave : free list side (returns new tags, head pointer, valid and free count)
interface free_list_if #(
  parameter int NUM_PR    = 64,
  parameter int NUM_FL    = NUM_PR - 32,
  parameter int NUM_SUPER = 2
);
  localparam int TW = $clog2(NUM_PR);
  localparam int PW = $clog2(NUM_FL) + 1;
  logic                          en;
  logic                          dispatch_en;
  logic [NUM_SUPER-1:0][4:0]     dest_idx;
  logic [NUM_SUPER-1:0]          retire_en;
  logic [NUM_SUPER-1:0][4:0]     retire_dest_idx;
  logic [NUM_SUPER-1:0][TW-1:0]  Told_idx;
  logic                          rollback_en;
  logic [PW-1:0]                 rollback_head;
  logic [NUM_SUPER-1:0][TW-1:0]  T_idx;
  logic [PW-1:0]                 FL_head;
  logic                          FL_valid;
  logic [PW-1:0]                 free_count;
  modport master (
    output en, dispatch_en, dest_idx, retire_en, retire_dest_idx, Told_idx, rollback_en, rollback_head,
    input  T_idx, FL_head, FL_valid, free_count
  );
  modport slave (
    input  en, dispatch_en, dest_idx, retire_en, retire_dest_idx, Told_idx, rollback_en, rollback_head,
    output T_idx, FL_head, FL_valid, free_count
  );
endinterface

// File: rtl/free_list.sv
// free_list: two-wide circular physical-register free list with checkpoint rollback
//   clock, reset : rising-edge clock, synchronous active-high reset
//   fl (slave)   : en/dispatch_en/dest_idx pop tags into T_idx when FL_valid;
//                  retire_en/retire_dest_idx/Told_idx push reclaimed tags;
//                  rollback_en/rollback_head restore the head pointer;
//                  FL_head and free_count expose the pointer state
module free_list #(
  parameter int NUM_PR    = 64,
  parameter int NUM_FL    = NUM_PR - 32,
  parameter int NUM_SUPER = 2,
  parameter int ZERO_PR   = 31,
  parameter int ZERO_REG  = 31
) (
  input logic       clock,
  input logic       reset,
  free_list_if.slave fl
);
  localparam int TW = $clog2(NUM_PR);
  localparam int IW = $clog2(NUM_FL);
  localparam int PW = IW + 1;
  logic [TW-1:0]        entry [NUM_FL];
  logic [PW-1:0]        head, tail, head1, tail1, need, pushes, free_count;
  logic [NUM_SUPER-1:0] need_v, push_v;
  logic [TW-1:0]        h0, h1;
  logic                 pop;
  logic [PW:0]          fill_next;
  always_comb begin
    need_v = '0;
    push_v = '0;
    for (int i = 0; i < NUM_SUPER; i++) begin
      need_v[i] = fl.dest_idx[i] != 5'(ZERO_REG);
      push_v[i] = fl.retire_en[i] && fl.retire_dest_idx[i] != 5'(ZERO_REG) && fl.Told_idx[i] != TW'(ZERO_PR);
    end
  end
  assign need       = PW'(need_v[0]) + PW'(need_v[1]);
  assign pushes     = PW'(push_v[0]) + PW'(push_v[1]);
  assign free_count = tail - head;
  assign head1      = head + PW'(1);
  // second retired tag lands right after the first one actually pushed
  assign tail1      = push_v[0] ? tail + PW'(1) : tail;
  assign h0         = entry[head[IW-1:0]];
  assign h1         = entry[head1[IW-1:0]];
  // slot 1 takes the head tag when slot 0 writes the zero register
  assign fl.T_idx[0]   = need_v[0] ? h0 : TW'(ZERO_PR);
  assign fl.T_idx[1]   = need_v[1] ? (need_v[0] ? h1 : h0) : TW'(ZERO_PR);
  assign fl.FL_valid   = free_count >= need && !fl.rollback_en;
  assign fl.FL_head    = head;
  assign fl.free_count = free_count;
  assign pop           = fl.en && fl.dispatch_en && fl.FL_valid;
  assign fill_next     = {1'b0, free_count} + {1'b0, pushes} - (pop ? {1'b0, need} : '0);
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= PW'(NUM_FL);
      for (int i = 0; i < NUM_FL; i++) entry[i] <= TW'(NUM_PR - NUM_FL + i);
    end else if (fl.en) begin
      assert (fl.rollback_en || fill_next <= (PW+1)'(NUM_FL));
      head <= fl.rollback_en ? fl.rollback_head : pop ? head + need : head;
      tail <= tail + pushes;
      if (push_v[0]) entry[tail[IW-1:0]] <= fl.Told_idx[0];
      if (push_v[1]) entry[tail1[IW-1:0]] <= fl.Told_idx[1];
    end
  end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: scoreboard bench for free_list; stimulus queues expected outputs, a negedge monitor compares
module tb_free_list;
  logic clock = 0;
  logic reset = 1;
  always #5 clock = ~clock;
  free_list_if #(.NUM_PR(64), .NUM_FL(32), .NUM_SUPER(2)) b ();
  free_list #(.NUM_PR(64), .NUM_FL(32), .NUM_SUPER(2), .ZERO_PR(31), .ZERO_REG(31)) dut (
    .clock(clock),
    .reset(reset),
    .fl(b.slave)
  );
  typedef struct {
    string name;
    int    t0, t1, v, hd, cnt;
    bit    ct;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(string n, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, req);
    end
  endtask
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.ct) begin
        chk({e.name, ".T0"}, int'(b.T_idx[0]), e.t0);
        chk({e.name, ".T1"}, int'(b.T_idx[1]), e.t1);
      end
      chk({e.name, ".valid"}, int'(b.FL_valid), e.v);
      chk({e.name, ".head"}, int'(b.FL_head), e.hd);
      chk({e.name, ".count"}, int'(b.free_count), e.cnt);
    end
  end
  task automatic exp_push(string n, int t0, int t1, int v, int hd, int cnt, bit ct = 1);
    exp_t e;
    e.name = n; e.t0 = t0; e.t1 = t1; e.v = v; e.hd = hd; e.cnt = cnt; e.ct = ct;
    q.push_back(e);
  endtask
  task automatic drive(bit de, int d0, int d1, bit [1:0] re = 0, int rd0 = 0, int rd1 = 0, int to0 = 0, int to1 = 0);
    b.dispatch_en        = de;
    b.dest_idx[0]        = 5'(d0);
    b.dest_idx[1]        = 5'(d1);
    b.retire_en          = re;
    b.retire_dest_idx[0] = 5'(rd0);
    b.retire_dest_idx[1] = 5'(rd1);
    b.Told_idx[0]        = 6'(to0);
    b.Told_idx[1]        = 6'(to1);
    b.rollback_en        = 0;
    b.rollback_head      = '0;
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  int fl_m[$];
  int live[$];
  initial begin
    b.en = 1;
    drive(0, 31, 31);
    repeat (2) tick();
    reset = 0;
    exp_push("rst_disp", 32, 33, 1, 0, 32);
    drive(1, 5, 3); tick();
    exp_push("slot0_zero", 31, 34, 1, 2, 30);
    drive(1, 31, 7); tick();
    b.en = 0;
    exp_push("en_low", 35, 36, 1, 3, 29);
    drive(1, 5, 6); tick();
    b.en = 1;
    exp_push("zero_retire", 31, 31, 1, 3, 29);
    drive(0, 31, 31, 2'b11, 31, 4, 20, 31); tick();
    for (int k = 0; k < 14; k++) begin
      exp_push("drain", 35 + 2 * k, 36 + 2 * k, 1, 3 + 2 * k, 29 - 2 * k);
      drive(1, 1, 2); tick();
    end
    exp_push("short", 63, 32, 0, 31, 1);
    drive(1, 1, 2); tick();
    exp_push("retire_one", 63, 32, 0, 31, 1);
    drive(1, 1, 2, 2'b01, 4, 0, 10, 0); tick();
    exp_push("pop_push", 63, 10, 1, 31, 2);
    drive(1, 1, 2, 2'b11, 4, 5, 40, 41); tick();
    exp_push("pushed", 40, 41, 1, 33, 2);
    drive(1, 1, 2); tick();
    exp_push("empty_need1", 31, 35, 0, 35, 0);
    drive(1, 31, 5); tick();
    exp_push("empty_need0", 31, 31, 1, 35, 0);
    drive(1, 31, 31); tick();
    reset = 1;
    exp_push("reset_mid", 35, 36, 0, 35, 0);
    drive(1, 1, 2, 2'b11, 1, 2, 50, 51); tick();
    reset = 0;
    exp_push("after_rst", 32, 33, 1, 0, 32);
    drive(1, 1, 2); tick();
    exp_push("after_rst2", 34, 35, 1, 2, 30);
    drive(1, 1, 2); tick();
    for (int j = 0; j < 3; j++) begin
      exp_push("bundle", 36 + 2 * j, 37 + 2 * j, 1, 4 + 2 * j, 28 - 2 * j);
      drive(1, 1, 2); tick();
    end
    exp_push("rollback", 42, 43, 0, 10, 22);
    drive(1, 1, 2);
    b.rollback_en = 1;
    b.rollback_head = 6'd4;
    tick();
    exp_push("post_rb", 36, 37, 1, 4, 28);
    drive(1, 1, 2); tick();
    reset = 1;
    drive(0, 31, 31); tick();
    reset = 0;
    fl_m.delete();
    live.delete();
    for (int i = 0; i < 32; i++) fl_m.push_back(32 + i);
    begin
      int hd = 0;
      for (int c = 0; c < 200; c++) begin
        int d0, d1, n0, n1, need, v, r, t0, t1, to0, to1;
        bit de;
        d0 = ($urandom_range(0, 3) == 0) ? 31 : int'($urandom_range(0, 30));
        d1 = ($urandom_range(0, 3) == 0) ? 31 : int'($urandom_range(0, 30));
        de = $urandom_range(0, 3) != 0;
        n0 = d0 != 31; n1 = d1 != 31; need = n0 + n1;
        v = fl_m.size() >= need;
        t0 = n0 ? (v ? fl_m[0] : 0) : 31;
        t1 = n1 ? (v ? (n0 ? fl_m[1] : fl_m[0]) : 0) : 31;
        r = $urandom_range(0, 2);
        if (r > live.size()) r = live.size();
        to0 = r > 0 ? live[0] : 0;
        to1 = r > 1 ? live[1] : 0;
        exp_push("random", t0, t1, v, hd, fl_m.size(), v != 0);
        drive(de, d0, d1, r == 0 ? 2'b00 : r == 1 ? 2'b01 : 2'b11, 1, 2, to0, to1);
        if (de && v) begin
          repeat (need) live.push_back(fl_m.pop_front());
          hd = (hd + need) % 64;
        end
        repeat (r) fl_m.push_back(live.pop_front());
        tick();
      end
      exp_push("final", 0, 0, 1, hd, fl_m.size(), 0);
      drive(0, 31, 31); tick();
    end
    repeat (3) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
